// File: rtl/multi_clk_div.sv
// Multi-channel programmable clock divider / tick generator.
// Each channel counts H = DIVIDER*cnt cycles per half-period and either toggles
// its output (50% duty, period 2H) or emits a one-cycle pulse every H cycles.
// The divide select and mode are shadowed and only reloaded at an event, so
// reprogramming never produces a runt pulse.

module multi_clk_div_ch #(
    parameter int CNT_W   = 6,
    parameter int DIVIDER = 5000,
    parameter int CTR_W   = 19
) (
    input  logic             clockin,
    input  logic             rst_n,
    input  logic             restart,
    input  logic             en,
    input  logic [CNT_W-1:0] cnt,
    input  logic             mode,
    output logic             clockout,
    output logic             tick
);

    logic [CTR_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] act_cnt_q, act_cnt_d;
    logic             act_mode_q, act_mode_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [CTR_W-1:0] term;
    logic             idle;

    // Constant multiply; the product always fits in CTR_W by construction.
    assign term = CTR_W'(DIVIDER) * CTR_W'(act_cnt_q) - CTR_W'(1);
    assign idle = !en || (act_cnt_q == '0);

    // Next-state: restart/idle clear and track the shadows, terminal edge fires an event.
    always_comb begin
        count_d    = count_q;
        act_cnt_d  = act_cnt_q;
        act_mode_d = act_mode_q;
        clk_d      = clk_q;
        tick_d     = 1'b0;
        if (restart || idle) begin
            count_d    = '0;
            clk_d      = 1'b0;
            act_cnt_d  = cnt;
            act_mode_d = mode;
        end else if (count_q == term) begin
            count_d    = '0;
            tick_d     = 1'b1;
            clk_d      = act_mode_q ? 1'b1 : !clk_q;
            act_cnt_d  = cnt;
            act_mode_d = mode;
        end else begin
            count_d = count_q + CTR_W'(1);
            if (act_mode_q) clk_d = 1'b0;
        end
    end

    // Channel state register with synchronous active-low reset.
    always_ff @(posedge clockin) begin
        if (!rst_n) begin
            count_q    <= '0;
            act_cnt_q  <= '0;
            act_mode_q <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            count_q    <= count_d;
            act_cnt_q  <= act_cnt_d;
            act_mode_q <= act_mode_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
        end
    end

    assign clockout = clk_q;
    assign tick     = tick_q;

endmodule

module multi_clk_div #(
    parameter int NCH     = 4,
    parameter int CNT_W   = 6,
    parameter int DIVIDER = 5000,
    parameter int CTR_W   = $clog2(DIVIDER*(2**CNT_W-1)+1)
) (
    input  logic                 clockin,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       en,
    input  logic [NCH*CNT_W-1:0] cnt,
    input  logic [NCH-1:0]       mode,
    input  logic                 restart,
    output logic [NCH-1:0]       clockout,
    output logic [NCH-1:0]       tick
);

    // One independent divider per channel; only reset and restart are shared.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        multi_clk_div_ch #(
            .CNT_W  (CNT_W),
            .DIVIDER(DIVIDER),
            .CTR_W  (CTR_W)
        ) u_ch (
            .clockin (clockin),
            .rst_n   (rst_n),
            .restart (restart),
            .en      (en[i]),
            .cnt     (cnt[i*CNT_W +: CNT_W]),
            .mode    (mode[i]),
            .clockout(clockout[i]),
            .tick    (tick[i])
        );
    end

endmodule

// File: tb/tb_multi_clk_div.sv
// Bench for multi_clk_div: an event-time model (absolute cycle of the next
// event per channel) checked every cycle, plus literal latency/period pins.

module tb_multi_clk_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        restart = 1'b0;
    logic [3:0]  en0 = '0, mode0 = '0;
    logic [15:0] cnt0 = '0;
    logic [3:0]  co0, tk0;
    logic [1:0]  en1 = '0, mode1 = '0;
    logic [7:0]  cnt1 = '0;
    logic [1:0]  co1, tk1;

    int vectors = 0;
    int miscompares = 0;
    longint cyc = 0;

    bit     m_lvl[2][4];
    bit     m_tk[2][4];
    int     m_sc[2][4];
    bit     m_sm[2][4];
    longint m_nxt[2][4];

    multi_clk_div #(.NCH(4), .CNT_W(4), .DIVIDER(4)) u0 (
        .clockin(clk), .rst_n(rst_n), .en(en0), .cnt(cnt0), .mode(mode0),
        .restart(restart), .clockout(co0), .tick(tk0));

    multi_clk_div #(.NCH(2), .CNT_W(4), .DIVIDER(1)) u1 (
        .clockin(clk), .rst_n(rst_n), .en(en1), .cnt(cnt1), .mode(mode1),
        .restart(restart), .clockout(co1), .tick(tk1));

    always #5 clk = ~clk;

    // Model: an event is due at cycle start+H; reload picks the next deadline.
    task automatic model_step(input int d, input int div, input int nch,
                              input logic [3:0] e, input logic [15:0] c,
                              input logic [3:0] md);
        for (int i = 0; i < nch; i++) begin
            if (!rst_n) begin
                m_lvl[d][i] = 0; m_tk[d][i] = 0; m_sc[d][i] = 0;
                m_sm[d][i] = 0; m_nxt[d][i] = 0;
            end else if (restart || !e[i] || m_sc[d][i] == 0) begin
                m_lvl[d][i] = 0; m_tk[d][i] = 0;
                m_sc[d][i] = int'(c[i*4 +: 4]); m_sm[d][i] = md[i];
                m_nxt[d][i] = cyc + longint'(div * m_sc[d][i]);
            end else if (cyc == m_nxt[d][i]) begin
                m_tk[d][i] = 1;
                m_lvl[d][i] = m_sm[d][i] ? 1'b1 : !m_lvl[d][i];
                m_sc[d][i] = int'(c[i*4 +: 4]); m_sm[d][i] = md[i];
                m_nxt[d][i] = cyc + longint'(div * m_sc[d][i]);
            end else begin
                m_tk[d][i] = 0;
                if (m_sm[d][i]) m_lvl[d][i] = 0;
            end
        end
    endtask

    // Advance the model on every active edge using the inputs seen by the DUT.
    always @(posedge clk) begin
        cyc = cyc + 1;
        model_step(0, 4, 4, en0, cnt0, mode0);
        model_step(1, 1, 2, {2'b0, en1}, {8'b0, cnt1}, {2'b0, mode1});
    end

    // Compare every channel of both instances against the model each cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            vectors += 2;
            if (co0[i] !== m_lvl[0][i] || tk0[i] !== m_tk[0][i]) begin
                miscompares++;
                $display("FAIL u0_ch%0d cyc=%0d clockout=%b tick=%b required %b %b",
                         i, cyc, co0[i], tk0[i], m_lvl[0][i], m_tk[0][i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            vectors += 2;
            if (co1[i] !== m_lvl[1][i] || tk1[i] !== m_tk[1][i]) begin
                miscompares++;
                $display("FAIL u1_ch%0d cyc=%0d clockout=%b tick=%b required %b %b",
                         i, cyc, co1[i], tk1[i], m_lvl[1][i], m_tk[1][i]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got %0d required %0d", name, act, exp);
        end
    endtask

    // Count negedges until u0 clockout/tick of channel ch equals val.
    task automatic wait_for(input bit use_tick, input int ch, input logic val,
                            output int n);
        logic s;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            s = use_tick ? tk0[ch] : co0[ch];
        end while (s !== val && n < 400);
        if (s !== val) begin
            miscompares++;
            $display("FAIL timeout ch%0d waiting for %b", ch, val);
        end
    endtask

    int n, r0, r2;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_clockout", int'(co0), 0);
        chk("reset_tick", int'(tk0), 0);
        rst_n = 1'b1;

        // 1: ch0 toggle, H=12
        cnt0[3:0] = 4'd3;
        @(negedge clk);
        en0[0] = 1'b1;
        wait_for(0, 0, 1'b1, n); chk("t1_first_rise", n, 12);
        chk("t1_tick_at_rise", int'(tk0[0]), 1);
        chk("t1_others_low", int'(co0[3:1]), 0);
        wait_for(0, 0, 1'b0, n); chk("t1_high_len", n, 12);
        wait_for(0, 0, 1'b1, n); chk("t1_low_len", n, 12);

        // 2: ch1 pulse H=4; DIVIDER=1 pulse and toggle
        cnt0[7:4] = 4'd1; mode0[1] = 1'b1;
        cnt1 = {4'd1, 4'd1}; mode1 = 2'b01;
        @(negedge clk);
        en0[1] = 1'b1; en1 = 2'b11;
        wait_for(0, 1, 1'b1, n); chk("t2_pulse_first", n, 4);
        chk("t2_h1_pulse_high", int'(co1[0]), 1);
        chk("t2_h1_tick_high", int'(tk1[0]), 1);
        wait_for(0, 1, 1'b0, n); chk("t2_pulse_width", n, 1);
        wait_for(0, 1, 1'b1, n); chk("t2_pulse_gap", n, 3);
        @(negedge clk);
        chk("t2_h1_still_high", int'(co1[0]), 1);

        // 3: mid-period reprogramming of ch0
        wait_for(1, 0, 1'b1, n);
        repeat (5) @(negedge clk);
        cnt0[3:0] = 4'd1;
        wait_for(1, 0, 1'b1, n); chk("t3_old_period_kept", n, 7);
        wait_for(1, 0, 1'b1, n); chk("t3_new_period", n, 4);
        cnt0[3:0] = 4'd0;
        repeat (12) @(negedge clk);
        chk("t3_stopped_clockout", int'(co0[0]), 0);
        chk("t3_stopped_tick", int'(tk0[0]), 0);

        // 4: restart phase-aligns ch0 (H=12) and ch2 (H=20)
        cnt0[3:0] = 4'd3; cnt0[11:8] = 4'd5; en0[2] = 1'b1;
        repeat (7) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        r0 = 0; r2 = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (r0 == 0 && co0[0]) r0 = k;
            if (r2 == 0 && co0[2]) r2 = k;
        end
        chk("t4_ch0_rise", r0, 12);
        chk("t4_ch2_rise", r2, 20);
        restart = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_restart_held", int'(co0) | int'(tk0), 0);
        end
        restart = 1'b0;

        // 5: reset mid-high-phase
        wait_for(0, 0, 1'b1, n);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_reset_clockout", int'(co0), 0);
        chk("t5_reset_tick", int'(tk0), 0);
        rst_n = 1'b1;
        wait_for(0, 0, 1'b1, n); chk("t5_rise_after_reset", n, 13);

        // 6: max select on ch3, H=60
        cnt0[15:12] = 4'd15;
        @(negedge clk);
        en0[3] = 1'b1;
        wait_for(0, 3, 1'b1, n); chk("t6_first_rise", n, 60);
        wait_for(0, 3, 1'b0, n); chk("t6_high_len", n, 60);
        wait_for(0, 3, 1'b1, n); chk("t6_low_len", n, 60);
        repeat (25) @(negedge clk);
        en0[3] = 1'b0;
        @(negedge clk);
        chk("t6_en_drop", int'(co0[3]), 0);
        en0[3] = 1'b1;
        wait_for(0, 3, 1'b1, n); chk("t6_rise_after_reenable", n, 60);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
